// File: rtl/matmul_sequencer_if.sv
// Control and instruction bus between the matmul sequencer and its ALU-side consumer.
// The sequencer is the master. The host or testbench side is the slave.
interface matmul_sequencer_if;
    logic        start;
    logic        hold;
    logic [31:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic [3:0]  row;
    logic [3:0]  col;

    modport master (
        input  start, hold,
        output instr, instr_valid, busy, done, row, col
    );

    modport slave (
        output start, hold,
        input  instr, instr_valid, busy, done, row, col
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Emits the full single-cycle-ALU instruction stream for C = A x B on NxN matrices in ALU memory.
// The FSM state names the step to present next. Each un-held edge registers that step's word and advances.
module matmul_sequencer #(
    parameter int N      = 3,
    parameter int A_BASE = 0,
    parameter int B_BASE = 9,
    parameter int C_BASE = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    matmul_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_CLR, S_LDA, S_LDB, S_MUL, S_ACC, S_STORE, S_DONE
    } state_t;

    localparam logic [31:0] INIT_W  = 32'h02F7B822;
    localparam logic [31:0] CLR_W   = 32'h02529022;
    localparam logic [31:0] LDA_W   = 32'h8EF00000;
    localparam logic [31:0] LDB_W   = 32'h8EF10000;
    localparam logic [31:0] MUL_W   = 32'h02119818;
    localparam logic [31:0] ACC_W   = 32'h02539020;
    localparam logic [31:0] STORE_W = 32'hAEF20000;
    localparam logic [3:0]  LAST    = 4'(N - 1);

    state_t      state_q;
    logic [3:0]  i_q, j_q, k_q;
    logic [31:0] instr_q;
    logic        valid_q, busy_q, done_q;

    logic [15:0] addr_a, addr_b, addr_c;
    logic [31:0] word_d;

    assign addr_a = 16'(A_BASE) + 16'(i_q) * 16'(N) + 16'(k_q);
    assign addr_b = 16'(B_BASE) + 16'(k_q) * 16'(N) + 16'(j_q);
    assign addr_c = 16'(C_BASE) + 16'(i_q) * 16'(N) + 16'(j_q);

    always_comb begin
        word_d = 32'h0;
        case (state_q)
            S_INIT:  word_d = INIT_W;
            S_CLR:   word_d = CLR_W;
            S_LDA:   word_d = LDA_W   | {16'h0, addr_a};
            S_LDB:   word_d = LDB_W   | {16'h0, addr_b};
            S_MUL:   word_d = MUL_W;
            S_ACC:   word_d = ACC_W;
            S_STORE: word_d = STORE_W | {16'h0, addr_c};
            default: word_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= 4'd0;
            j_q     <= 4'd0;
            k_q     <= 4'd0;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_IDLE) begin
                instr_q <= 32'h0;
                valid_q <= 1'b0;
                if (bus.start) begin
                    busy_q <= 1'b1;
                    // A held start parks on INIT so the word is issued once hold drops.
                    if (bus.hold) begin
                        state_q <= S_INIT;
                    end else begin
                        instr_q <= INIT_W;
                        valid_q <= 1'b1;
                        state_q <= S_CLR;
                    end
                end
            end else if (bus.hold) begin
                instr_q <= 32'h0;
                valid_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                instr_q <= 32'h0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
            end else begin
                instr_q <= word_d;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
                case (state_q)
                    S_INIT: state_q <= S_CLR;
                    S_CLR:  state_q <= S_LDA;
                    S_LDA:  state_q <= S_LDB;
                    S_LDB:  state_q <= S_MUL;
                    S_MUL:  state_q <= S_ACC;
                    S_ACC: begin
                        if (k_q == LAST) begin
                            k_q     <= 4'd0;
                            state_q <= S_STORE;
                        end else begin
                            k_q     <= k_q + 4'd1;
                            state_q <= S_LDA;
                        end
                    end
                    S_STORE: begin
                        if (j_q != LAST) begin
                            j_q     <= j_q + 4'd1;
                            state_q <= S_CLR;
                        end else if (i_q != LAST) begin
                            j_q     <= 4'd0;
                            i_q     <= i_q + 4'd1;
                            state_q <= S_CLR;
                        end else begin
                            // Counters return to zero so the next start begins at element (0,0).
                            i_q     <= 4'd0;
                            j_q     <= 4'd0;
                            state_q <= S_DONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.row         = i_q;
    assign bus.col         = j_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Drives the sequencer into a behavioural MIPS-style ALU model.
// Every emitted word is compared against an expected stream, and the resulting C matrix is compared against known products.
module tb_matmul_sequencer;

    localparam int N      = 3;
    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int C_BASE = 24;

    localparam logic [31:0] INIT_W  = 32'h02F7B822;
    localparam logic [31:0] CLR_W   = 32'h02529022;
    localparam logic [31:0] LDA_W   = 32'h8EF00000;
    localparam logic [31:0] LDB_W   = 32'h8EF10000;
    localparam logic [31:0] MUL_W   = 32'h02119818;
    localparam logic [31:0] ACC_W   = 32'h02539020;
    localparam logic [31:0] STORE_W = 32'hAEF20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    matmul_sequencer_if bus();

    matmul_sequencer #(.N(N), .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU. It executes whatever word is on the bus at each rising edge.
    logic [31:0] regs [32];
    logic [31:0] mem  [40];
    int          a_init [9];
    int          b_init [9];
    logic        load_req;

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        for (int m = 0; m < 40; m++) mem[m] = 32'h0;
    end

    always @(posedge clk) begin
        logic [31:0] w;
        logic [4:0]  rs, rt, rd;
        logic [31:0] ea;
        w  = bus.instr;
        rs = w[25:21];
        rt = w[20:16];
        rd = w[15:11];
        ea = regs[rs] + {16'h0, w[15:0]};
        if (load_req) begin
            for (int e = 0; e < 9; e++) begin
                mem[A_BASE + e] = 32'(a_init[e]);
                mem[B_BASE + e] = 32'(b_init[e]);
                mem[C_BASE + e] = 32'h0;
            end
        end else begin
            case (w[31:26])
                6'h00: if (rd != 5'd0) begin
                    case (w[5:0])
                        6'h20: regs[rd] = regs[rs] + regs[rt];
                        6'h22: regs[rd] = regs[rs] - regs[rt];
                        6'h18: regs[rd] = regs[rs] * regs[rt];
                        default: ;
                    endcase
                end
                6'h23: if (ea < 40 && rt != 5'd0) regs[rt] = mem[ea];
                6'h2B: if (ea < 40) mem[ea] = regs[rt];
                default: ;
            endcase
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          nvalid;
    logic [31:0] exp_q[$];
    logic [31:0] last_word;
    logic [31:0] prev_cycle_word;
    bit          got_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and consume one scoreboard entry whenever a valid word shows up.
    task automatic step();
        prev_cycle_word = bus.instr;
        @(negedge clk);
        got_valid = 1'b0;
        if (bus.instr_valid) begin
            got_valid = 1'b1;
            nvalid++;
            last_word = bus.instr;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL stream_extra: observed %h expected no further word", bus.instr);
            end
            if (exp_q.size() > 0) chk($sformatf("stream[%0d]", nvalid - 1), bus.instr, exp_q.pop_front());
        end else begin
            chk("nop_word", bus.instr, 32'h0);
        end
        $display("cycle word=%h valid=%0b busy=%0b done=%0b row=%0d col=%0d",
                 bus.instr, bus.instr_valid, bus.busy, bus.done, bus.row, bus.col);
    endtask

    task automatic push_stream();
        exp_q.delete();
        exp_q.push_back(INIT_W);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_q.push_back(CLR_W);
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back(LDA_W | 32'(A_BASE + i * N + k));
                    exp_q.push_back(LDB_W | 32'(B_BASE + k * N + j));
                    exp_q.push_back(MUL_W);
                    exp_q.push_back(ACC_W);
                end
                exp_q.push_back(STORE_W | 32'(C_BASE + i * N + j));
            end
    endtask

    task automatic load_mats();
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_c(input string tag, input int exp_c [9]);
        for (int e = 0; e < 9; e++)
            chk($sformatf("%s_C[%0d]", tag, e), mem[C_BASE + e], 32'(exp_c[e]));
    endtask

    task automatic run(input int hold_at, input int pulse_at, input int abort_at,
                       input bit idle_hold, output int cycles);
        bit held;
        held   = 1'b0;
        push_stream();
        nvalid = 0;
        cycles = 0;
        bus.start = 1'b1;
        bus.hold  = idle_hold;
        step(); cycles++;
        bus.start = 1'b0;
        if (idle_hold) begin
            chk("idle_hold_valid", 32'(bus.instr_valid), 32'd0);
            chk("idle_hold_busy", 32'(bus.busy), 32'd1);
            step(); cycles++;
            bus.hold = 1'b0;
            step(); cycles++;
        end
        chk("first_word", bus.instr, INIT_W);
        chk("busy_running", 32'(bus.busy), 32'd1);
        while (!bus.done && cycles < 1000) begin
            if (abort_at > 0 && nvalid == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_instr", bus.instr, 32'h0);
                chk("abort_valid", 32'(bus.instr_valid), 32'd0);
                chk("abort_busy", 32'(bus.busy), 32'd0);
                chk("abort_row", 32'(bus.row), 32'd0);
                return;
            end
            if (hold_at > 0 && nvalid == hold_at && !held) begin
                held = 1'b1;
                bus.hold = 1'b1;
                repeat (5) begin
                    step(); cycles++;
                    chk("hold_valid", 32'(bus.instr_valid), 32'd0);
                    chk("hold_busy", 32'(bus.busy), 32'd1);
                end
                bus.hold = 1'b0;
                step(); cycles++;
                chk("mul_after_hold", bus.instr, MUL_W);
            end else begin
                bus.start = (pulse_at > 0 && nvalid == pulse_at);
                step(); cycles++;
                bus.start = 1'b0;
                if (got_valid && nvalid == 15) chk("elem0_store", last_word, 32'hAEF20018);
                if (got_valid && nvalid == 18) chk("elem1_ldb", last_word, 32'h8EF1000A);
            end
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        chk("valid_count", 32'(nvalid), 32'd127);
        chk("store_before_done", prev_cycle_word, 32'hAEF20020);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        step();
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c1, c2, c3, cx, c5;
        int ident [9];
        int a_mat [9];
        int b_mat [9];
        int c_ident [9];
        int c_prod [9];
        ident   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        a_mat   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        b_mat   = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        c_ident = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        c_prod  = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        load_req  = 1'b0;
        nvalid    = 0;
        last_word = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_row", 32'(bus.row), 32'd0);
        chk("rst_col", 32'(bus.col), 32'd0);
        rst_n = 1'b1;
        step();

        a_init = a_mat;
        b_init = ident;
        load_mats();
        run(0, 30, 0, 1'b0, c1);
        check_c("ident", c_ident);

        b_init = b_mat;
        load_mats();
        run(0, 0, 0, 1'b0, c2);
        check_c("prod", c_prod);

        load_mats();
        run(74, 0, 0, 1'b0, c3);
        check_c("held", c_prod);
        chk("hold_cycles", 32'(c3), 32'(c2 + 5));

        bus.hold = 1'b1;
        step();
        chk("idle_hold_noeffect_busy", 32'(bus.busy), 32'd0);
        bus.hold = 1'b0;
        step();

        load_mats();
        run(0, 0, 60, 1'b0, cx);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("after_abort_busy", 32'(bus.busy), 32'd0);

        load_mats();
        run(0, 0, 0, 1'b1, c5);
        check_c("restart", c_prod);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
